// File: rtl/xfda_recv.sv
`default_nettype none
// ============================================================================
// Module   : xfda_recv
// Brief    : 8N1 serial receiver that assembles three good bytes into one
//            24-bit word (first byte in [23:16]). Optional inter-byte timeout
//            is enabled by defining XFDA_RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module xfda_recv #(
    parameter int CLKS_PER_BIT      = 5208,
    parameter int IDLE_TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        Rx,
    output logic [23:0] data_out,
    output logic        valid,
    output logic        frame_err,
    output logic        timeout,
    output logic        busy
);

    localparam int                 c_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic               r_rx_meta;
    logic               r_rx_s;
    logic               r_rx_prev;
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [15:0]        r_word;
    logic [1:0]         r_byte_cnt;
    logic               w_to_hit;
    logic               w_fall;

    // Line resets to idle-high so the first real start bit is seen as an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= Rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_s;
    assign busy   = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_word     <= '0;
            r_byte_cnt <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
        end else if (!enable) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_byte_cnt <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (w_to_hit) begin
                        r_byte_cnt <= '0;
                    end
                    if (w_fall) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == c_HALF_M1) begin
                        r_cnt   <= '0;
                        r_state <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_FULL_M1) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        if (r_rx_s) begin
                            if (r_byte_cnt == 2'd2) begin
                                data_out   <= {r_word, r_shift};
                                valid      <= 1'b1;
                                r_byte_cnt <= '0;
                            end else begin
                                r_word     <= {r_word[7:0], r_shift};
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                            end
                        end else begin
                            frame_err  <= 1'b1;
                            r_byte_cnt <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef XFDA_RX_TIMEOUT_EN
    localparam int                c_TO_W     = $clog2(CLKS_PER_BIT * IDLE_TIMEOUT_BITS + 1);
    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(CLKS_PER_BIT * IDLE_TIMEOUT_BITS);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout;

    assign w_to_hit = (r_state == S_IDLE) && (r_byte_cnt != 2'd0) && (r_to_cnt == c_TO_LIMIT);
    assign timeout  = r_timeout;

    // Only a partial word sitting in IDLE ages; any frame activity restarts it
    always_ff @(posedge clk) begin
        if (reset || !enable || (r_state != S_IDLE) || (r_byte_cnt == 2'd0)) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_to_hit) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b1;
        end else begin
            r_to_cnt  <= r_to_cnt + 1'b1;
            r_timeout <= 1'b0;
        end
    end
`else
    assign w_to_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xfda_recv.sv
`default_nettype none
// ============================================================================
// Module   : tb_xfda_recv
// Brief    : Directed self-checking bench for xfda_recv (16 clk/bit, 4-bit
//            timeout). Timeout expectations follow XFDA_RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xfda_recv;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        Rx = 1'b1;
    logic [23:0] data_out;
    logic        valid;
    logic        frame_err;
    logic        timeout;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    int n_valid = 0;
    int n_ferr  = 0;
    int n_to    = 0;
    int n_viol  = 0;
    logic prev_valid = 1'b0;
    logic prev_ferr  = 1'b0;
    logic prev_to    = 1'b0;
    logic busy_mid_ok;

    xfda_recv #(
        .CLKS_PER_BIT      (CPB),
        .IDLE_TIMEOUT_BITS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .Rx        (Rx),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts strobes and flags overlaps or stretched pulses
    always @(negedge clk) begin
        if (valid === 1'b1)     n_valid <= n_valid + 1;
        if (frame_err === 1'b1) n_ferr  <= n_ferr + 1;
        if (timeout === 1'b1)   n_to    <= n_to + 1;
        if ((valid === 1'b1 && prev_valid) || (frame_err === 1'b1 && prev_ferr) ||
            (timeout === 1'b1 && prev_to) ||
            ((32'(valid === 1'b1) + 32'(frame_err === 1'b1) + 32'(timeout === 1'b1)) > 1))
            n_viol <= n_viol + 1;
        prev_valid <= (valid === 1'b1);
        prev_ferr  <= (frame_err === 1'b1);
        prev_to    <= (timeout === 1'b1);
    end

    task automatic idle(input int n);
        Rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        Rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            if (i == 3) busy_mid_ok = busy_mid_ok & (busy === 1'b1);
        end
        send_bit(stop);
        Rx = 1'b1;
    endtask

    task automatic test_reset;
        int base;
        reset = 1'b1;
        Rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        base  = n_valid + n_ferr + n_to;
        repeat (200) @(negedge clk);
        n_checks++;
        if (data_out !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h expected %h", data_out, 24'h0); end
        n_checks++;
        if ({valid, frame_err, timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {valid, frame_err, timeout}); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (n_valid + n_ferr + n_to - base !== 0) begin n_fail++; $display("FAIL reset_idle_pulses: got %0d expected 0", n_valid + n_ferr + n_to - base); end
    endtask

    task automatic test_nominal;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        busy_mid_ok = 1'b1;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h0F, 1'b1);
        idle(20);
        n_checks++;
        if (data_out !== 24'hA53C0F) begin n_fail++; $display("FAIL nominal_data: got %h expected %h", data_out, 24'hA53C0F); end
        n_checks++;
        if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL nominal_valid_count: got %0d expected 1", n_valid - v0); end
        n_checks++;
        if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL nominal_frame_err: got %0d expected 0", n_ferr - f0); end
        n_checks++;
        if (busy_mid_ok !== 1'b1) begin n_fail++; $display("FAIL nominal_busy_mid_frame: got %b expected 1", busy_mid_ok); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL nominal_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_frame_err;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        idle(16);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h9A, 1'b1);
        idle(20);
        n_checks++;
        if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - f0); end
        n_checks++;
        if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL ferr_valid_count: got %0d expected 1", n_valid - v0); end
        n_checks++;
        if (data_out !== 24'h56789A) begin n_fail++; $display("FAIL ferr_data: got %h expected %h", data_out, 24'h56789A); end
    endtask

    task automatic test_false_start;
        int base, v0;
        base = n_valid + n_ferr + n_to;
        Rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(30);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy: got %b expected 0", busy); end
        n_checks++;
        if (n_valid + n_ferr + n_to - base !== 0) begin n_fail++; $display("FAIL false_start_pulses: got %0d expected 0", n_valid + n_ferr + n_to - base); end
        v0 = n_valid;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        idle(20);
        n_checks++;
        if (data_out !== 24'h010203) begin n_fail++; $display("FAIL false_start_data: got %h expected %h", data_out, 24'h010203); end
        n_checks++;
        if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL false_start_valid_count: got %0d expected 1", n_valid - v0); end
    endtask

    // Two good bytes plus a truncated third, leaving the line high
    task automatic partial_word;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        Rx = 1'b1;
    endtask

    task automatic test_reset_mid_word;
        int v0;
        v0 = n_valid;
        partial_word();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (data_out !== 24'h0) begin n_fail++; $display("FAIL reset_mid_data_cleared: got %h expected %h", data_out, 24'h0); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
        idle(32);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        idle(20);
        n_checks++;
        if (data_out !== 24'hAABBCC) begin n_fail++; $display("FAIL reset_mid_data: got %h expected %h", data_out, 24'hAABBCC); end
        n_checks++;
        if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL reset_mid_valid_count: got %0d expected 1", n_valid - v0); end
    endtask

    task automatic test_enable_mid_word;
        int v0;
        v0 = n_valid;
        partial_word();
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL enable_mid_busy: got %b expected 0", busy); end
        idle(32);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        idle(20);
        n_checks++;
        if (data_out !== 24'hAABBCC) begin n_fail++; $display("FAIL enable_mid_data: got %h expected %h", data_out, 24'hAABBCC); end
        n_checks++;
        if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL enable_mid_valid_count: got %0d expected 1", n_valid - v0); end
    endtask

    task automatic test_timeout;
        int v0, t0;
        logic [23:0] exp_word;
        int          exp_to;
`ifdef XFDA_RX_TIMEOUT_EN
        exp_word = 24'h223344;
        exp_to   = 1;
`else
        exp_word = 24'h112233;
        exp_to   = 0;
`endif
        v0 = n_valid; t0 = n_to;
        send_byte(8'h11, 1'b1);
        idle(80);
        n_checks++;
        if (n_to - t0 !== exp_to) begin n_fail++; $display("FAIL timeout_count: got %0d expected %0d", n_to - t0, exp_to); end
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        idle(20);
        n_checks++;
        if (data_out !== exp_word) begin n_fail++; $display("FAIL timeout_data: got %h expected %h", data_out, exp_word); end
        n_checks++;
        if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL timeout_valid_count: got %0d expected 1", n_valid - v0); end
    endtask

    task automatic test_pulse_rules;
        n_checks++;
        if (n_viol !== 0) begin n_fail++; $display("FAIL pulse_rules: got %0d violations expected 0", n_viol); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_frame_err();
        test_false_start();
        test_reset_mid_word();
        test_enable_mid_word();
        test_timeout();
        test_pulse_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
